pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Drives per-register stall (hold) and flush (insert bubble) controls for the IF/ID, ID/EX, EX/M and M/WB pipeline registers.
- Resolves load-use hazards, M-stage control redirects (branch/jal/jalr) and data-memory wait states through a small FSM.

Parameters:
- LOAD_LAT, 1, number of bubble cycles inserted for a load-use hazard (1..7)
- CNT_W, 16, width of the perf counters (used only with the optional feature)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- rs1_raddr_D  in  5  rs1 index of the instruction in ID
- rs2_raddr_D  in  5  rs2 index of the instruction in ID
- rd_waddr_EX  in  5  destination register of the instruction in EX
- rd_wen_EX  in  1  EX instruction writes rd
- mem_read_EX  in  1  EX instruction is a load
- branch_M  in  1  M instruction is a conditional branch
- zero_M  in  1  branch condition true
- jal_M  in  1  M instruction is jal
- jalr_M  in  1  M instruction is jalr
- dmem_req_M  in  1  M instruction accesses data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_redirect  out  1  PC takes the M-stage target this cycle
- stall_F  out  1  hold PC and IF/ID
- stall_D  out  1  hold ID/EX inputs (ID instruction stays in ID)
- stall_EX  out  1  hold EX/M
- stall_M  out  1  hold M/WB
- flush_D  out  1  load bubble into IF/ID
- flush_EX  out  1  load bubble into ID/EX
- flush_M  out  1  load bubble into EX/M
- flush_W  out  1  load bubble into M/WB
- busy  out  1  FSM not in RUN

Behaviour:
- Terms: redirect = (branch_M & zero_M) | jal_M | jalr_M.
- Terms: lu_hazard = mem_read_EX & rd_wen_EX & (rd_waddr_EX != 0) & ((rd_waddr_EX == rs1_raddr_D) | (rd_waddr_EX == rs2_raddr_D)).
- Terms: mem_wait = dmem_req_M & ~dmem_ready.
- FSM states: RUN, LDSTALL, MEMWAIT. A 3-bit bubble counter bcnt counts load bubbles.
- Reset: while rst_n=0 on a clock edge, state <= RUN and bcnt <= 0.
- Reset outputs: on any cycle where rst_n=0, all flush_* = 1, all stall_* = 0, pc_redirect = 0, busy = 0.
- Outputs are combinational from state plus the inputs. Latency is 0: a hazard seen in cycle N is acted on in cycle N.
- Priority 1, mem_wait: stall_F/D/EX/M = 1, flush_W = 1, all other flushes = 0, pc_redirect = 0.
  - Next state is MEMWAIT; bcnt is frozen.
  - When dmem_ready rises, the FSM resolves that cycle with the normal priorities below (MEMWAIT then behaves as RUN, or as LDSTALL if bcnt != 0).
- Priority 2, redirect: pc_redirect = 1 and flush_D = flush_EX = flush_M = 1 for exactly that cycle; no stalls.
  - Next state RUN, bcnt <= 0, so a pending load stall is aborted.
- Priority 3, lu_hazard in RUN: stall_F = stall_D = 1 and flush_EX = 1 (bubble).
  - If LOAD_LAT > 1: bcnt <= LOAD_LAT-1 and next state LDSTALL. Otherwise stay in RUN.
- In LDSTALL: stall_F = stall_D = 1, flush_EX = 1 and bcnt decrements each cycle. Return to RUN when bcnt reaches 1, so the total bubble count is LOAD_LAT.
- No hazard: all controls 0.
- A stalled register is never also flushed in the same cycle. Stall overrides flush per register.
- rd_waddr_EX = 0 never creates a hazard.
- Reset asserted mid-stall: next cycle is state RUN with bcnt = 0.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, add outputs ld_stall_cnt, mem_stall_cnt and flush_cnt, each CNT_W wide.
  - ld_stall_cnt counts load bubbles.
  - mem_stall_cnt counts mem_wait cycles.
  - flush_cnt counts redirect events.
- Counters saturate at all-ones and clear on reset.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load-use, LOAD_LAT=1: rd_waddr_EX=5, mem_read_EX=1, rd_wen_EX=1, rs1_raddr_D=5 -> one cycle with stall_F=stall_D=flush_EX=1, busy=0. With rd_waddr_EX=0 -> no stall.
- Load-use, LOAD_LAT=3: same stimulus -> three consecutive cycles of stall_F/D+flush_EX, busy=1 in cycles 2-3, then RUN.
- Branch taken: branch_M=1, zero_M=1 -> pc_redirect=1 and flush_D/EX/M=1 for one cycle. With zero_M=0 -> all controls 0.
- Memory wait: dmem_req_M=1, dmem_ready=0 for 4 cycles, then 1 -> stall_F/D/EX/M=1 and flush_W=1 for 4 cycles, released on the ready cycle.
- Simultaneous events: jalr_M=1 while in LDSTALL with bcnt=2 -> redirect wins, FSM returns to RUN. mem_wait together with jal_M -> stall first, redirect on the ready cycle.
- Reset mid-MEMWAIT: rst_n=0 for 1 cycle -> all flush=1 and stall=0 during reset, state RUN afterwards. With PIPE_HAZARD_PERF_EN, all counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose : hazard-control bundle between the 5-stage datapath and pipe_hazard_ctrl.
// Latency : combinational signal bundle; it holds no state of its own.
// Backpr. : none; stall_* and flush_* are the pipeline's only hold mechanism.
// Ports   : master = datapath (drives hazard sources, receives controls);
//           slave  = controller (receives hazard sources, drives controls).
interface pipe_hazard_ctrl_if;
   // hazard sources
   logic [4:0] rs1_raddr_D;
   logic [4:0] rs2_raddr_D;
   logic [4:0] rd_waddr_EX;
   logic       rd_wen_EX;
   logic       mem_read_EX;
   logic       branch_M;
   logic       zero_M;
   logic       jal_M;
   logic       jalr_M;
   logic       dmem_req_M;
   logic       dmem_ready;
   // pipeline controls
   logic       pc_redirect;
   logic       stall_F;
   logic       stall_D;
   logic       stall_EX;
   logic       stall_M;
   logic       flush_D;
   logic       flush_EX;
   logic       flush_M;
   logic       flush_W;
   logic       busy;

   modport master (
      output rs1_raddr_D, rs2_raddr_D, rd_waddr_EX, rd_wen_EX, mem_read_EX,
             branch_M, zero_M, jal_M, jalr_M, dmem_req_M, dmem_ready,
      input  pc_redirect, stall_F, stall_D, stall_EX, stall_M,
             flush_D, flush_EX, flush_M, flush_W, busy
   );

   modport slave (
      input  rs1_raddr_D, rs2_raddr_D, rd_waddr_EX, rd_wen_EX, mem_read_EX,
             branch_M, zero_M, jal_M, jalr_M, dmem_req_M, dmem_ready,
      output pc_redirect, stall_F, stall_D, stall_EX, stall_M,
             flush_D, flush_EX, flush_M, flush_W, busy
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : stall/flush sequencing for the IF/ID, ID/EX, EX/M and M/WB registers
//           (load-use bubbles, M-stage redirects, data-memory wait states).
// Latency : 0 cycles; controls are combinational from FSM state plus inputs.
// Backpr. : a data-memory wait holds F/D/EX/M and bubbles M/WB until dmem_ready.
// Ports   : clk, rst_n (synchronous, active-low); hz = pipe_hazard_ctrl_if.slave.
//           With PIPE_HAZARD_PERF_EN defined: ld_stall_cnt, mem_stall_cnt and
//           flush_cnt saturating perf counters (CNT_W bits each).
module pipe_hazard_ctrl #(
   parameter int unsigned LOAD_LAT = 1,   // load-use bubbles, 1..7
   parameter int unsigned CNT_W    = 16   // perf counter width
) (
   input  logic               clk,
   input  logic               rst_n,
   pipe_hazard_ctrl_if.slave  hz
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0]   ld_stall_cnt,
   output logic [CNT_W-1:0]   mem_stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
`endif
);

   if (LOAD_LAT < 1 || LOAD_LAT > 7 || CNT_W < 1) begin : g_bad_param
      $error("pipe_hazard_ctrl: LOAD_LAT must be 1..7 and CNT_W >= 1");
   end

   // Bubbles still owed after the first one, loaded on hazard detection.
   localparam logic [2:0] BCNT_LOAD = 3'(LOAD_LAT - 1);

   typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} state_t;

   state_t     state, state_nxt;
   logic [2:0] bcnt, bcnt_nxt;

   logic redirect, lu_hazard, mem_wait, in_ld;

   // Raw controls before the reset override and stall masking.
   logic pcr_raw;
   logic stall_f_raw, stall_d_raw, stall_ex_raw, stall_m_raw;
   logic flush_d_raw, flush_ex_raw, flush_m_raw, flush_w_raw;
   logic ld_bubble;

   assign redirect  = (hz.branch_M & hz.zero_M) | hz.jal_M | hz.jalr_M;
   assign lu_hazard = hz.mem_read_EX & hz.rd_wen_EX & (hz.rd_waddr_EX != 5'd0) &
                      ((hz.rd_waddr_EX == hz.rs1_raddr_D) |
                       (hz.rd_waddr_EX == hz.rs2_raddr_D));
   assign mem_wait  = hz.dmem_req_M & ~hz.dmem_ready;

   // A memory wait can interrupt a load stall; bcnt is frozen across the wait,
   // so on release MEMWAIT resumes the stall if bubbles are still owed.
   assign in_ld = (state == LDSTALL) || ((state == MEMWAIT) && (bcnt != 3'd0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
         bcnt  <= 3'd0;
      end else begin
         state <= state_nxt;
         bcnt  <= bcnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = RUN;
      bcnt_nxt     = bcnt;
      pcr_raw      = 1'b0;
      stall_f_raw  = 1'b0;
      stall_d_raw  = 1'b0;
      stall_ex_raw = 1'b0;
      stall_m_raw  = 1'b0;
      flush_d_raw  = 1'b0;
      flush_ex_raw = 1'b0;
      flush_m_raw  = 1'b0;
      flush_w_raw  = 1'b0;
      ld_bubble    = 1'b0;

      if (mem_wait) begin
         stall_f_raw  = 1'b1;
         stall_d_raw  = 1'b1;
         stall_ex_raw = 1'b1;
         stall_m_raw  = 1'b1;
         flush_w_raw  = 1'b1;
         state_nxt    = MEMWAIT;
      end else if (redirect) begin
         // Redirect kills everything younger than M, including a pending load stall.
         pcr_raw     = 1'b1;
         flush_d_raw = 1'b1;
         flush_ex_raw = 1'b1;
         flush_m_raw = 1'b1;
         bcnt_nxt    = 3'd0;
      end else if (in_ld) begin
         stall_f_raw  = 1'b1;
         stall_d_raw  = 1'b1;
         flush_ex_raw = 1'b1;
         ld_bubble    = 1'b1;
         bcnt_nxt     = bcnt - 3'd1;
         state_nxt    = (bcnt == 3'd1) ? RUN : LDSTALL;
      end else if (lu_hazard) begin
         stall_f_raw  = 1'b1;
         stall_d_raw  = 1'b1;
         flush_ex_raw = 1'b1;
         ld_bubble    = 1'b1;
         if (LOAD_LAT > 1) begin
            bcnt_nxt  = BCNT_LOAD;
            state_nxt = LDSTALL;
         end
      end
   end

   // Reset forces bubbles everywhere and releases all holds. Outside reset,
   // a held register never also takes a bubble.
   assign hz.pc_redirect = rst_n & pcr_raw;
   assign hz.stall_F     = rst_n & stall_f_raw;
   assign hz.stall_D     = rst_n & stall_d_raw;
   assign hz.stall_EX    = rst_n & stall_ex_raw;
   assign hz.stall_M     = rst_n & stall_m_raw;
   assign hz.flush_D     = ~rst_n | (flush_d_raw  & ~stall_d_raw);
   assign hz.flush_EX    = ~rst_n | (flush_ex_raw & ~stall_ex_raw);
   assign hz.flush_M     = ~rst_n | (flush_m_raw  & ~stall_m_raw);
   assign hz.flush_W     = ~rst_n | flush_w_raw;
   assign hz.busy        = rst_n & (state != RUN);

`ifdef PIPE_HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ld_stall_cnt  <= '0;
         mem_stall_cnt <= '0;
         flush_cnt     <= '0;
      end else begin
         if (ld_bubble && (ld_stall_cnt != '1))
            ld_stall_cnt <= ld_stall_cnt + 1'b1;
         if (mem_wait && (mem_stall_cnt != '1))
            mem_stall_cnt <= mem_stall_cnt + 1'b1;
         if (pcr_raw && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : self-checking bench for pipe_hazard_ctrl at LOAD_LAT=1 and LOAD_LAT=3.
// Latency : outputs compared mid-cycle against a behavioural reference model.
// Backpr. : n/a (bench drives every hazard source directly).
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic wen = 0, mrd = 0, br = 0, zr = 0, jal = 0, jalr = 0, req = 0, rdy = 0;

   pipe_hazard_ctrl_if if1 ();
   pipe_hazard_ctrl_if if3 ();

   assign if1.rs1_raddr_D = rs1;  assign if3.rs1_raddr_D = rs1;
   assign if1.rs2_raddr_D = rs2;  assign if3.rs2_raddr_D = rs2;
   assign if1.rd_waddr_EX = rd;   assign if3.rd_waddr_EX = rd;
   assign if1.rd_wen_EX   = wen;  assign if3.rd_wen_EX   = wen;
   assign if1.mem_read_EX = mrd;  assign if3.mem_read_EX = mrd;
   assign if1.branch_M    = br;   assign if3.branch_M    = br;
   assign if1.zero_M      = zr;   assign if3.zero_M      = zr;
   assign if1.jal_M       = jal;  assign if3.jal_M       = jal;
   assign if1.jalr_M      = jalr; assign if3.jalr_M      = jalr;
   assign if1.dmem_req_M  = req;  assign if3.dmem_req_M  = req;
   assign if1.dmem_ready  = rdy;  assign if3.dmem_ready  = rdy;

`ifdef PIPE_HAZARD_PERF_EN
   logic [15:0] ldc1, memc1, flc1, ldc3, memc3, flc3;
`endif

   pipe_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .hz(if1)
`ifdef PIPE_HAZARD_PERF_EN
      , .ld_stall_cnt(ldc1), .mem_stall_cnt(memc1), .flush_cnt(flc1)
`endif
   );

   pipe_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .hz(if3)
`ifdef PIPE_HAZARD_PERF_EN
      , .ld_stall_cnt(ldc3), .mem_stall_cnt(memc3), .flush_cnt(flc3)
`endif
   );

   // {pc_redirect, stall_F, stall_D, stall_EX, stall_M, flush_D, flush_EX, flush_M, flush_W, busy}
   logic [9:0] act [2];
   assign act[0] = {if1.pc_redirect, if1.stall_F, if1.stall_D, if1.stall_EX, if1.stall_M,
                    if1.flush_D, if1.flush_EX, if1.flush_M, if1.flush_W, if1.busy};
   assign act[1] = {if3.pc_redirect, if3.stall_F, if3.stall_D, if3.stall_EX, if3.stall_M,
                    if3.flush_D, if3.flush_EX, if3.flush_M, if3.flush_W, if3.busy};

   localparam logic [9:0] C_RESET  = 10'b0000011110;
   localparam logic [9:0] C_MEMW   = 10'b0111100010;
   localparam logic [9:0] C_REDIR  = 10'b1000011100;
   localparam logic [9:0] C_BUBBLE = 10'b0110001000;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: bubbles still owed and "previous cycle was a memory wait".
   int lat [2] = '{1, 3};
   int owed [2] = '{0, 0};
   bit waiting [2] = '{0, 0};
   int m_ld [2] = '{0, 0};
   int m_mem [2] = '{0, 0};
   int m_fl [2] = '{0, 0};

   task automatic idle();
      rs1 = 0; rs2 = 0; rd = 0; wen = 0; mrd = 0;
      br = 0; zr = 0; jal = 0; jalr = 0; req = 0; rdy = 0;
   endtask

   // Check one cycle: inputs were applied 1 time unit after the last posedge;
   // outputs are sampled at the following negedge, then the model advances.
   task automatic cyc(input string tag);
      logic [9:0] exp;
      bit redir, lu, mw, busy_now;
      #4;
      redir = (br && zr) || jal || jalr;
      lu    = mrd && wen && (rd != 0) && (rd == rs1 || rd == rs2);
      mw    = req && !rdy;
`ifdef PIPE_HAZARD_PERF_EN
      n_assert++;
      assert ({ldc1, memc1, flc1, ldc3, memc3, flc3} ===
              {16'(m_ld[0]), 16'(m_mem[0]), 16'(m_fl[0]), 16'(m_ld[1]), 16'(m_mem[1]), 16'(m_fl[1])})
      else begin
         n_fail++;
         $error("FAIL %s perf: got ld=%0d/%0d mem=%0d/%0d fl=%0d/%0d expected ld=%0d/%0d mem=%0d/%0d fl=%0d/%0d",
                tag, ldc1, ldc3, memc1, memc3, flc1, flc3,
                m_ld[0], m_ld[1], m_mem[0], m_mem[1], m_fl[0], m_fl[1]);
      end
`endif
      for (int k = 0; k < 2; k++) begin
         busy_now = (rst_n == 1'b1) && (waiting[k] || owed[k] > 0);
         if (!rst_n) begin
            exp = C_RESET;
            owed[k] = 0; waiting[k] = 0;
            m_ld[k] = 0; m_mem[k] = 0; m_fl[k] = 0;
         end else if (mw) begin
            exp = C_MEMW;
            waiting[k] = 1;
            m_mem[k]++;
         end else if (redir) begin
            exp = C_REDIR;
            owed[k] = 0; waiting[k] = 0;
            m_fl[k]++;
         end else if (owed[k] > 0) begin
            exp = C_BUBBLE;
            owed[k]--; waiting[k] = 0;
            m_ld[k]++;
         end else if (lu) begin
            exp = C_BUBBLE;
            owed[k] = lat[k] - 1; waiting[k] = 0;
            m_ld[k]++;
         end else begin
            exp = '0;
            waiting[k] = 0;
         end
         exp[0] = busy_now;
         n_assert++;
         assert (act[k] === exp)
         else begin
            n_fail++;
            $error("FAIL %s lat=%0d: got %b expected %b", tag, lat[k], act[k], exp);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst_n = 0;
      cyc("reset");
      rst_n = 1;
      cyc("idle_after_reset");

      // load-use on rs1, hazard visible for one cycle
      rd = 5; mrd = 1; wen = 1; rs1 = 5;
      cyc("lu_first");
      idle();
      repeat (3) cyc("lu_tail");
      // load-use on rs2
      rd = 9; mrd = 1; wen = 1; rs2 = 9;
      cyc("lu_rs2");
      idle();
      repeat (3) cyc("lu_rs2_tail");
      // x0 destination never hazards
      rd = 0; mrd = 1; wen = 1; rs1 = 0; rs2 = 0;
      cyc("lu_x0");
      idle();
      cyc("lu_x0_after");

      br = 1; zr = 1;
      cyc("branch_taken");
      zr = 0;
      cyc("branch_not_taken");
      idle();

      req = 1; rdy = 0;
      repeat (4) cyc("memwait");
      rdy = 1;
      cyc("mem_ready");
      idle();
      cyc("mem_after");

      // jalr while LOAD_LAT=3 controller sits in LDSTALL with two bubbles owed
      rd = 7; mrd = 1; wen = 1; rs1 = 7;
      cyc("lu_before_jalr");
      idle(); jalr = 1;
      cyc("jalr_in_ldstall");
      idle();
      repeat (2) cyc("after_jalr");

      // memory wait interrupting a load stall, then resuming it
      rd = 3; mrd = 1; wen = 1; rs2 = 3;
      cyc("lu_before_memwait");
      idle(); req = 1;
      repeat (2) cyc("memwait_in_ldstall");
      rdy = 1;
      cyc("ldstall_resume");
      idle();
      repeat (2) cyc("resume_tail");

      // memory wait together with jal: stall first, redirect on ready
      req = 1; jal = 1;
      repeat (2) cyc("memwait_jal");
      rdy = 1;
      cyc("jal_on_ready");
      idle();
      cyc("jal_after");

      // reset in the middle of a memory wait
      req = 1;
      repeat (2) cyc("memwait_pre_reset");
      rst_n = 0;
      cyc("reset_mid_memwait");
      rst_n = 1;
      idle();
      cyc("run_after_reset");

      // randomized traffic with small register indices to make hazards frequent
      for (int i = 0; i < 600; i++) begin
         rs1  = 5'($urandom_range(3));
         rs2  = 5'($urandom_range(3));
         rd   = 5'($urandom_range(3));
         wen  = ($urandom_range(3) != 0);
         mrd  = ($urandom_range(1) == 1);
         br   = ($urandom_range(7) == 0);
         zr   = ($urandom_range(1) == 1);
         jal  = ($urandom_range(15) == 0);
         jalr = ($urandom_range(15) == 0);
         req  = ($urandom_range(3) == 0);
         rdy  = ($urandom_range(1) == 1);
         rst_n = ($urandom_range(63) != 0);
         cyc("random");
      end
      rst_n = 1;
      idle();
      cyc("final_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
